// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, index-width helper and index type for the register file
package rf_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_REGS = 4;
  function automatic int rf_addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int RF_IDX_W = rf_addr_w(DEF_NUM_REGS);
  typedef logic [RF_IDX_W-1:0] rf_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, issue hazard/stall detection and pending count
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = rf_addr_w(NUM_REGS),
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                ctrl_regwrite,
  input  logic [ADDR_W-1:0]   write_reg,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_en,
  input  logic                issue_use1,
  input  logic                issue_use2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     pending
);
  logic [NUM_REGS-1:0] busy_q, busy_d, clr, set, eff;
  // hazard check; with bypass a register retiring this cycle no longer blocks issue
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) clr[i] = ctrl_regwrite && write_reg == ADDR_W'(i);
    eff = BYPASS ? busy_q & ~clr : busy_q;
    stall = issue_valid && ((issue_use1 && eff[rs1]) || (issue_use2 && eff[rs2]) || (issue_rd_en && eff[issue_rd]));
  end
  // next busy state: write-back clears, accepted issue sets, set wins on collision
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) set[i] = issue_valid && !stall && issue_rd_en && issue_rd == ADDR_W'(i);
    busy_d = (busy_q & ~clr) | set;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end
  // busy bit register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) busy_q <= '0;
    else busy_q <= busy_d;
  end
  // population count of outstanding writes
  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REGS; i++) pending = pending + {{ADDR_W{1'b0}}, busy_q[i]};
  end
  assign busy_vec = busy_q;
endmodule

// File: rtl/rf_sb.sv
// rf_sb: register file with two read ports, one write port, optional bypass/zero register and a busy scoreboard
module rf_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = rf_addr_w(NUM_REGS),
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic [DATA_W-1:0]   rval1,
  output logic [DATA_W-1:0]   rval2,
  input  logic                ctrl_regwrite,
  input  logic [ADDR_W-1:0]   write_reg,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_en,
  input  logic                issue_use1,
  input  logic                issue_use2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     pending
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic wr_ok;
  // next storage contents; writes to a hard-wired zero register are dropped
  always_comb begin
    regs_d = regs_q;
    wr_ok = ctrl_regwrite && !(ZERO_REG && write_reg == '0);
    if (wr_ok) regs_d[write_reg] = write_data;
  end
  // storage array
  always_ff @(posedge clock or posedge clear) begin
    if (clear) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  // read muxes: zero register first, then same-cycle forwarding, then stored data
  always_comb begin
    rval1 = (ZERO_REG && rs1 == '0) ? '0 : (BYPASS && ctrl_regwrite && write_reg == rs1) ? write_data : regs_q[rs1];
    rval2 = (ZERO_REG && rs2 == '0) ? '0 : (BYPASS && ctrl_regwrite && write_reg == rs2) ? write_data : regs_q[rs2];
  end
  rf_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clock(clock),
    .clear(clear),
    .rs1(rs1),
    .rs2(rs2),
    .ctrl_regwrite(ctrl_regwrite),
    .write_reg(write_reg),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_rd_en(issue_rd_en),
    .issue_use1(issue_use1),
    .issue_use2(issue_use2),
    .stall(stall),
    .busy_vec(busy_vec),
    .pending(pending)
  );
endmodule
